// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
package regfile_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_READ = 2;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks a pointer over registers 1..DEPTH-1, one per cycle.
// clr_start pulses in the cycle a request is accepted; clr_busy marks the walk.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_start,
    output logic [ADDR_W-1:0] clr_ptr
);

    localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] LAST_PTR  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ZERO_PTR  = {ADDR_W{1'b0}};

    rf_state_e         state_r;
    rf_state_e         state_nxt_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] ptr_nxt_s;

    // State and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RF_IDLE;
            ptr_r   <= ZERO_PTR;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Next-state logic; the walk exits on the last register so ptr never wraps
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            RF_IDLE: begin
                if (clr_req) begin
                    state_nxt_s = RF_CLEAR;
                    ptr_nxt_s   = FIRST_PTR;
                end else begin
                    state_nxt_s = RF_IDLE;
                    ptr_nxt_s   = ZERO_PTR;
                end
            end
            RF_CLEAR: begin
                if (ptr_r == LAST_PTR) begin
                    state_nxt_s = RF_IDLE;
                    ptr_nxt_s   = ZERO_PTR;
                end else begin
                    state_nxt_s = RF_CLEAR;
                    ptr_nxt_s   = ptr_r + ADDR_W'(1'b1);
                end
            end
            default: begin
                state_nxt_s = RF_IDLE;
                ptr_nxt_s   = ZERO_PTR;
            end
        endcase
    end

    // Output decode from the state register
    always_comb begin
        clr_busy  = (state_r == RF_CLEAR);
        clr_start = (state_r == RF_IDLE) && clr_req;
        clr_ptr   = ptr_r;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardwired zero register, pending-write
// scoreboard and sequenced clear. Optional bypass: define REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_READ = RF_NUM_READ
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [NUM_READ*ADDR_W-1:0]   raddr,
    output logic [NUM_READ*DATA_W-1:0]   rdata,
    output logic [NUM_READ-1:0]          rd_busy,
    input  logic                         issue_valid,
    input  logic [ADDR_W-1:0]            issue_addr,
    input  logic                         clr_req,
    output logic                         clr_busy
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [DEPTH-1:0]  BIT0     = {{(DEPTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ZERO_ADR = {ADDR_W{1'b0}};

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  sb_r;
    logic [DEPTH-1:0]  sb_nxt_s;
    logic [DEPTH-1:0]  wr_mask_s;
    logic [DEPTH-1:0]  iss_mask_s;
    logic              wr_en_s;
    logic              iss_en_s;
    logic              clr_busy_s;
    logic              clr_start_s;
    logic [ADDR_W-1:0] clr_ptr_s;

    regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy_s),
        .clr_start (clr_start_s),
        .clr_ptr   (clr_ptr_s)
    );

    assign clr_busy = clr_busy_s;

    // Qualified write/issue strobes; register 0 and an active clear block both
    always_comb begin
        wr_en_s    = we && (waddr != ZERO_ADR) && !clr_busy_s;
        iss_en_s   = issue_valid && (issue_addr != ZERO_ADR) && !clr_busy_s;
        wr_mask_s  = wr_en_s  ? (BIT0 << waddr)      : {DEPTH{1'b0}};
        iss_mask_s = iss_en_s ? (BIT0 << issue_addr) : {DEPTH{1'b0}};
    end

    // Scoreboard next value: the issue is the newer writer, so it beats a retiring write
    always_comb begin
        sb_nxt_s = clr_start_s ? {DEPTH{1'b0}} : ((sb_r & ~wr_mask_s) | iss_mask_s);
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_r <= {DEPTH{1'b0}};
        end else begin
            sb_r <= sb_nxt_s;
        end
    end

    // Register array: the clear walk owns the write port while it runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_r[k] <= {DATA_W{1'b0}};
            end
        end else if (clr_busy_s) begin
            regs_r[clr_ptr_s] <= {DATA_W{1'b0}};
        end else if (wr_en_s) begin
            regs_r[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] stored_s;

        assign ra_s     = raddr[i*ADDR_W +: ADDR_W];
        assign stored_s = (ra_s == ZERO_ADR) ? {DATA_W{1'b0}} : regs_r[ra_s];
`ifdef REGFILE_BYPASS_EN
        logic byp_s;

        assign byp_s                     = wr_en_s && (ra_s == waddr);
        assign rdata[i*DATA_W +: DATA_W] = byp_s ? wdata : stored_s;
        assign rd_busy[i]                = byp_s ? (iss_en_s && (issue_addr == waddr)) : sb_r[ra_s];
`else
        assign rdata[i*DATA_W +: DATA_W] = stored_s;
        assign rd_busy[i]                = sb_r[ra_s];
`endif
    end

endmodule
